rdcntrl_nbx: RTL

//  Parametrised SCA readout control for the CFEB block scheme.
//  - Tracks LCT match / no-match outcomes per SCA block over a configurable window of MTCH_BX block-ends.
//  - Queues matched blocks (block number, LCT phase, 2nd-block flag) in a trigger FIFO for the digitiser.
//  - Queues L1A numbers for the DAQ formatter.
//  - Adds overflow detection and counting over the fixed 3/4-BX block it replaces.

---
 rtl/cfeb_rd_pkg.sv | 24 ++
 rtl/rd_sync_fifo.sv | 112 +++++++++++
 rtl/rdcntrl_nbx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cfeb_rd_pkg.sv
// Shared definitions for the CFEB SCA readout-control slice.
//  - rd_state_e : readout state-machine codes seen on the STATE bus
//  - TF_META_W  : trigger-FIFO bits next to the block number (LCT phase, 2nd-block flag)
//  - LF_META_W  : L1A-FIFO bits next to the L1A number (50 ns phase)
//  - sat_add8   : saturating add used by the 8-bit overflow counter
package cfeb_rd_pkg;

  typedef enum logic [3:0] {
    ST_WRITE  = 4'd1,
    ST_READ   = 4'd3,
    ST_PREEND = 4'd12
  } rd_state_e;

  localparam int TF_META_W = 2;
  localparam int LF_META_W = 1;

  // Adds 0..2 events to an 8-bit count and clamps at 8'hFF.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/rd_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head.
// Ports:
//  CLK, RST   clock, asynchronous active-high reset
//  i_push     write i_din (accepted when not full, or when a pop happens in the same CLK)
//  i_pop      remove head entry (ignored when empty)
//  i_din      write data
//  o_dout     registered head entry
//  o_empty    registered empty flag (1 after reset)
//  o_full     registered full flag
//  o_ovf      1-CLK pulse: push refused because the FIFO was full and not popping
// With TMR=1 the pointers and the fill count are triplicated and majority voted.
module rd_sync_fifo #(
  parameter int W        = 8,
  parameter int DEPTH_LG = 3,
  parameter int TMR      = 0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_ovf
);

  localparam int DEPTH = 1 << DEPTH_LG;
  localparam int NC    = (TMR != 0) ? 3 : 1;

  logic [DEPTH_LG-1:0] r_wr  [NC];
  logic [DEPTH_LG-1:0] r_rd  [NC];
  logic [DEPTH_LG:0]   r_cnt [NC];
  logic [W-1:0]        r_mem [DEPTH];
  logic [W-1:0]        r_dout;
  logic                r_empty;
  logic                r_full;

  logic [DEPTH_LG-1:0] w_wr, w_rd, w_wr_next, w_rd_next;
  logic [DEPTH_LG:0]   w_cnt, w_cnt_next;
  logic                w_full_now, w_pop_ok, w_push_ok;

  generate
    if (NC == 3) begin : g_vote
      assign w_wr  = (r_wr[0]  & r_wr[1])  | (r_wr[0]  & r_wr[2])  | (r_wr[1]  & r_wr[2]);
      assign w_rd  = (r_rd[0]  & r_rd[1])  | (r_rd[0]  & r_rd[2])  | (r_rd[1]  & r_rd[2]);
      assign w_cnt = (r_cnt[0] & r_cnt[1]) | (r_cnt[0] & r_cnt[2]) | (r_cnt[1] & r_cnt[2]);
    end else begin : g_single
      assign w_wr  = r_wr[0];
      assign w_rd  = r_rd[0];
      assign w_cnt = r_cnt[0];
    end
  endgenerate

  assign w_full_now = (w_cnt == (DEPTH_LG+1)'(DEPTH));
  assign w_pop_ok   = i_pop & (w_cnt != '0);
  // A pop in the same CLK frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok  = i_push & (~w_full_now | w_pop_ok);
  assign o_ovf      = i_push & ~w_push_ok;

  assign w_wr_next = w_wr + DEPTH_LG'(w_push_ok);
  assign w_rd_next = w_rd + DEPTH_LG'(w_pop_ok);

  always_comb begin
    w_cnt_next = w_cnt;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_cnt_next = w_cnt + (DEPTH_LG+1)'(1);
      2'b01:   w_cnt_next = w_cnt - (DEPTH_LG+1)'(1);
      default: w_cnt_next = w_cnt;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NC; gi++) begin : g_copy
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_wr[gi]  <= '0;
          r_rd[gi]  <= '0;
          r_cnt[gi] <= '0;
        end else begin
          r_wr[gi]  <= w_wr_next;
          r_rd[gi]  <= w_rd_next;
          r_cnt[gi] <= w_cnt_next;
        end
      end
    end
  endgenerate

  // Storage is left unreset so it maps onto RAM; validity comes from the pointers.
  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[w_wr] <= i_din;
  end

  // The head register is loaded with the entry that will be at the head after this
  // CLK. When that slot is the one being written now, bypass the incoming data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dout  <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_dout  <= (w_push_ok && (w_rd_next == w_wr)) ? i_din : r_mem[w_rd_next];
      r_empty <= (w_cnt_next == '0);
      r_full  <= (w_cnt_next == (DEPTH_LG+1)'(DEPTH));
    end
  end

  assign o_dout  = r_dout;
  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/rdcntrl_nbx.sv
// SCA readout control for the CFEB block scheme.
// Tracks match / no-match history over MTCH_BX block-ends, queues matched blocks
// for the digitiser, queues L1A numbers for the DAQ formatter and flags overflow.
// Ports:
//  CLK, RST             clock, asynchronous active-high reset
//  PBEND                block-end strobe
//  STATE                readout SM state (1 = write slot, 3 = read slot)
//  MATCH, NO_MATCH      LCT outcome for the current block
//  GMATCH               push the pipelined L1A number
//  GTRG, ENBL50         L1A strobe and 50 ns phase sampled with it
//  LCT_PH, BLKIN        phase and number of the current block
//  TRGDONE, POPL1AN     pop trigger FIFO (in read slot) / pop L1A FIFO
//  PFIFO1, NOGTRG       window status
//  TEMPTY, FULL         trigger FIFO status
//  SCND_BLK, LCT_PH_OUT, BLKOUT   trigger FIFO head
//  L1AN_EMPTY, L1ANUM, L1A_PH_OUT L1A FIFO status and head
//  OVF, OVF_CNT         sticky overflow flag and saturating overflow count
module rdcntrl_nbx
  import cfeb_rd_pkg::*;
#(
  parameter int TMR         = 0,
  parameter int MTCH_BX     = 3,
  parameter int BLK_W       = 4,
  parameter int TF_DEPTH_LG = 3,
  parameter int LF_DEPTH_LG = 3,
  parameter int L1A_W       = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PBEND,
  input  logic [3:0]       STATE,
  input  logic             MATCH,
  input  logic             NO_MATCH,
  input  logic             GMATCH,
  input  logic             GTRG,
  input  logic             ENBL50,
  input  logic             LCT_PH,
  input  logic [BLK_W-1:0] BLKIN,
  input  logic             TRGDONE,
  input  logic             POPL1AN,
  output logic             PFIFO1,
  output logic             NOGTRG,
  output logic             TEMPTY,
  output logic             FULL,
  output logic             SCND_BLK,
  output logic             LCT_PH_OUT,
  output logic [BLK_W-1:0] BLKOUT,
  output logic             L1AN_EMPTY,
  output logic [L1A_W-1:0] L1ANUM,
  output logic             L1A_PH_OUT,
  output logic             OVF,
  output logic [7:0]       OVF_CNT
);

  localparam int NC   = (TMR != 0) ? 3 : 1;
  localparam int TF_W = BLK_W + TF_META_W;
  localparam int LF_W = L1A_W + LF_META_W;

  // History bit k covers the block that ended k-1 block-ends ago; bit 1 is the open block.
  logic [MTCH_BX:1] r_l       [NC];
  logic [MTCH_BX:1] r_f       [NC];
  logic [L1A_W-1:0] r_l1a_cnt [NC];

  logic [MTCH_BX:1] w_l, w_f;
  logic [L1A_W-1:0] w_l1a_cnt;

  logic             r_l1a_ph;
  logic [LF_W-1:0]  r_l1a_pipe;
  logic             r_tempty_d;
  logic             r_ovf;
  logic [7:0]       r_ovf_cnt;

  logic             w_yes, w_lno, w_is_read;
  logic             w_tf_empty, w_tf_ovf, w_lf_ovf;
  logic [TF_W-1:0]  w_tf_dout;
  logic [LF_W-1:0]  w_lf_dout;

  generate
    if (NC == 3) begin : g_vote
      assign w_l       = (r_l[0] & r_l[1]) | (r_l[0] & r_l[2]) | (r_l[1] & r_l[2]);
      assign w_f       = (r_f[0] & r_f[1]) | (r_f[0] & r_f[2]) | (r_f[1] & r_f[2]);
      assign w_l1a_cnt = (r_l1a_cnt[0] & r_l1a_cnt[1]) | (r_l1a_cnt[0] & r_l1a_cnt[2])
                       | (r_l1a_cnt[1] & r_l1a_cnt[2]);
    end else begin : g_single
      assign w_l       = r_l[0];
      assign w_f       = r_f[0];
      assign w_l1a_cnt = r_l1a_cnt[0];
    end

    for (genvar gi = 0; gi < NC; gi++) begin : g_copy
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_l[gi]       <= '0;
          r_f[gi]       <= '0;
          r_l1a_cnt[gi] <= '0;
        end else begin
          // Open-block flags accumulate until the block-end, then restart.
          r_l[gi][1] <= NO_MATCH | (w_l[1] & ~PBEND);
          r_f[gi][1] <= MATCH    | (w_f[1] & ~PBEND);
          if (PBEND) begin
            r_l[gi][MTCH_BX:2] <= w_l[MTCH_BX-1:1];
            r_f[gi][MTCH_BX:2] <= w_f[MTCH_BX-1:1];
          end
          if (GTRG) r_l1a_cnt[gi] <= w_l1a_cnt + L1A_W'(1);
        end
      end
    end
  endgenerate

  assign w_yes     = |w_f[MTCH_BX:2];
  assign w_lno     = |w_l[MTCH_BX:2];
  assign w_is_read = (STATE == ST_READ);
  // A match anywhere in the window keeps the blocks from being recycled.
  assign NOGTRG    = w_lno & ~w_yes;
  assign PFIFO1    = w_is_read & (w_yes | NOGTRG);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_l1a_ph   <= 1'b0;
      r_l1a_pipe <= '0;
      r_tempty_d <= 1'b1;
      r_ovf      <= 1'b0;
      r_ovf_cnt  <= 8'd0;
    end else begin
      if (GTRG) r_l1a_ph <= ENBL50;
      // GMATCH stores the count as it stood one CLK earlier.
      r_l1a_pipe <= {w_l1a_cnt, r_l1a_ph};
      // Digitiser sees a new entry only after it has passed through one write slot.
      if (STATE == ST_WRITE) r_tempty_d <= w_tf_empty;
      if (w_tf_ovf | w_lf_ovf) r_ovf <= 1'b1;
      r_ovf_cnt <= sat_add8(r_ovf_cnt, {1'b0, w_tf_ovf} + {1'b0, w_lf_ovf});
    end
  end

  rd_sync_fifo #(.W(TF_W), .DEPTH_LG(TF_DEPTH_LG), .TMR(TMR)) u_trig_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (PBEND & w_f[1]),
    .i_pop   (TRGDONE & w_is_read),
    .i_din   ({BLKIN, LCT_PH, w_f[2]}),
    .o_dout  (w_tf_dout),
    .o_empty (w_tf_empty),
    .o_full  (FULL),
    .o_ovf   (w_tf_ovf)
  );

  rd_sync_fifo #(.W(LF_W), .DEPTH_LG(LF_DEPTH_LG), .TMR(TMR)) u_l1a_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (GMATCH),
    .i_pop   (POPL1AN),
    .i_din   (r_l1a_pipe),
    .o_dout  (w_lf_dout),
    .o_empty (L1AN_EMPTY),
    .o_full  (),
    .o_ovf   (w_lf_ovf)
  );

  assign TEMPTY     = w_tf_empty | r_tempty_d;
  assign BLKOUT     = w_tf_dout[TF_W-1:2];
  assign LCT_PH_OUT = w_tf_dout[1];
  assign SCND_BLK   = w_tf_dout[0];
  assign L1ANUM     = w_lf_dout[LF_W-1:1];
  assign L1A_PH_OUT = w_lf_dout[0];
  assign OVF        = r_ovf;
  assign OVF_CNT    = r_ovf_cnt;

endmodule
